// File: rtl/audio_cfg_pkg.sv
// Shared FSM state type, WM8731 register map and the default codec init table.
// Pure declarations; no timing of its own.
package audio_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_CHECK,
        ST_GAP,
        ST_HALT
    } cfg_state_t;

    typedef struct packed {
        logic [6:0] addr;
        logic [8:0] val;
    } reg_wr_t;

    localparam logic [6:0] WM_LEFT_LINE_IN  = 7'h00;
    localparam logic [6:0] WM_RIGHT_LINE_IN = 7'h01;
    localparam logic [6:0] WM_LEFT_HP_OUT   = 7'h02;
    localparam logic [6:0] WM_RIGHT_HP_OUT  = 7'h03;
    localparam logic [6:0] WM_ANALOG_PATH   = 7'h04;
    localparam logic [6:0] WM_DIGITAL_PATH  = 7'h05;
    localparam logic [6:0] WM_POWER_DOWN    = 7'h06;
    localparam logic [6:0] WM_DIGITAL_IF    = 7'h07;
    localparam logic [6:0] WM_SAMPLE_RATE   = 7'h08;
    localparam logic [6:0] WM_ACTIVE        = 7'h09;
    localparam logic [6:0] WM_RESET         = 7'h0F;

    localparam int DEFAULT_NUM_REGS = 10;
    localparam int GAP_CYCLES       = 16;

    // Reset first so the codec starts from a known state; ACTIVE last so the
    // interface only starts clocking once everything else is programmed.
    function automatic reg_wr_t default_init_entry(input logic [3:0] index);
        reg_wr_t e;
        case (index)
            4'd0:    e = '{addr: WM_RESET,         val: 9'h000};
            4'd1:    e = '{addr: WM_LEFT_LINE_IN,  val: 9'h017};
            4'd2:    e = '{addr: WM_RIGHT_LINE_IN, val: 9'h017};
            4'd3:    e = '{addr: WM_LEFT_HP_OUT,   val: 9'h079};
            4'd4:    e = '{addr: WM_RIGHT_HP_OUT,  val: 9'h079};
            4'd5:    e = '{addr: WM_ANALOG_PATH,   val: 9'h012};
            4'd6:    e = '{addr: WM_DIGITAL_PATH,  val: 9'h000};
            4'd7:    e = '{addr: WM_POWER_DOWN,    val: 9'h000};
            4'd8:    e = '{addr: WM_DIGITAL_IF,    val: 9'h042};
            4'd9:    e = '{addr: WM_ACTIVE,        val: 9'h001};
            default: e = '{addr: 7'h00,            val: 9'h000};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/codec_init_rom.sv
// Init-table lookup: 4-bit index to {reg[6:0], val[8:0]}.
// Purely combinational, no handshake.
module codec_init_rom
    import audio_cfg_pkg::*;
(
    input  logic [3:0]  index,
    output logic [15:0] entry
);

    reg_wr_t row;

    always_comb begin
        row   = default_init_entry(index);
        entry = row;
    end

endmodule

// File: rtl/codec_config_sequencer.sv
// Walks the codec init table over an I2C controller, then serves runtime writes.
// One write in flight at a time; wr_req is held off until init completes and ignored in HALT.
module codec_config_sequencer
    import audio_cfg_pkg::*;
#(
    parameter logic [7:0] DEV_ADDR       = 8'h34,
    parameter int         NUM_REGS       = DEFAULT_NUM_REGS,
    parameter int         MAX_RETRIES    = 3,
    parameter int         TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    output logic        i2c_start,
    output logic [23:0] i2c_data,
    input  logic        i2c_done,
    input  logic        i2c_ack,
    input  logic        reconfig,
    input  logic        wr_req,
    input  logic [6:0]  wr_addr,
    input  logic [8:0]  wr_data,
    output logic        wr_ack,
    output logic        cfg_done,
    output logic        cfg_error,
    output logic [3:0]  err_index
);

    localparam int AW = $clog2(MAX_RETRIES + 2);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    cfg_state_t     state;
    cfg_state_t     state_nxt;

    logic           init_pend;
    logic           recfg_pend;
    logic           cur_init;
    logic           xfer_ok;
    logic [3:0]     idx;
    logic [AW-1:0]  attempts;
    logic [TW-1:0]  tmo;
    logic [3:0]     gap_cnt;

    logic           restart_now;
    logic           retry_hold;
    logic           retry_left;
    logic           sel_init;
    logic           sel_rt;
    logic           timed_out;
    logic           last_entry;
    logic [3:0]     sel_idx;
    logic [15:0]    rom_entry;

    codec_init_rom u_rom (
        .index (sel_idx),
        .entry (rom_entry)
    );

    // A latched reconfig is only honoured where no transfer is outstanding.
    assign restart_now = (reconfig || recfg_pend) &&
                         (state == ST_IDLE || state == ST_HALT || state == ST_SELECT);
    assign retry_hold  = (attempts != '0) && !restart_now;
    assign retry_left  = attempts < AW'(MAX_RETRIES);
    assign sel_init    = init_pend || restart_now;
    assign sel_rt      = !sel_init && wr_req && cfg_done;
    assign sel_idx     = restart_now ? 4'd0 : idx;
    assign timed_out   = tmo >= TW'(TIMEOUT_CYCLES - 1);
    assign last_entry  = idx == 4'(NUM_REGS - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (restart_now || init_pend || (wr_req && cfg_done)) begin
                    state_nxt = ST_SELECT;
                end
            end
            ST_SELECT: begin
                state_nxt = (retry_hold || sel_init || sel_rt) ? ST_ISSUE : ST_IDLE;
            end
            ST_ISSUE: begin
                state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!i2c_done) begin
                    state_nxt = ST_WAIT_DONE;
                end else if (timed_out) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_WAIT_DONE: begin
                if (i2c_done || timed_out) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_nxt = (xfer_ok || retry_left) ? ST_GAP : ST_HALT;
            end
            ST_GAP: begin
                if (gap_cnt == 4'(GAP_CYCLES - 1)) begin
                    state_nxt = ST_SELECT;
                end
            end
            ST_HALT: begin
                if (restart_now) begin
                    state_nxt = ST_SELECT;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        i2c_start = (state == ST_ISSUE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            init_pend  <= 1'b1;
            recfg_pend <= 1'b0;
            cur_init   <= 1'b0;
            xfer_ok    <= 1'b0;
            idx        <= '0;
            attempts   <= '0;
            tmo        <= '0;
            gap_cnt    <= '0;
            i2c_data   <= '0;
            wr_ack     <= 1'b0;
            cfg_done   <= 1'b0;
            cfg_error  <= 1'b0;
            err_index  <= '0;
        end else begin
            wr_ack <= 1'b0;

            if (reconfig && !restart_now) begin
                recfg_pend <= 1'b1;
            end

            if (restart_now) begin
                init_pend  <= 1'b1;
                recfg_pend <= 1'b0;
                idx        <= '0;
                attempts   <= '0;
                cfg_done   <= 1'b0;
                cfg_error  <= 1'b0;
                err_index  <= '0;
            end

            case (state)
                ST_SELECT: begin
                    // A retry reissues the word already held in i2c_data.
                    if (!retry_hold) begin
                        if (sel_init) begin
                            i2c_data <= {DEV_ADDR, rom_entry};
                            cur_init <= 1'b1;
                        end else if (sel_rt) begin
                            i2c_data <= {DEV_ADDR, wr_addr, wr_data};
                            cur_init <= 1'b0;
                        end
                    end
                end
                ST_ISSUE: begin
                    tmo <= TW'(1);
                end
                ST_WAIT_BUSY: begin
                    tmo     <= tmo + TW'(1);
                    xfer_ok <= 1'b0;
                end
                ST_WAIT_DONE: begin
                    tmo     <= tmo + TW'(1);
                    xfer_ok <= i2c_done && i2c_ack;
                end
                ST_CHECK: begin
                    gap_cnt <= '0;
                    if (xfer_ok) begin
                        attempts <= '0;
                        if (!cur_init) begin
                            wr_ack <= 1'b1;
                        end else if (last_entry) begin
                            init_pend <= 1'b0;
                            cfg_done  <= 1'b1;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end else if (retry_left) begin
                        attempts <= attempts + AW'(1);
                    end else begin
                        attempts  <= '0;
                        cfg_error <= 1'b1;
                        err_index <= idx;
                        if (!cur_init) begin
                            wr_ack <= 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Randomized-latency I2C slave stub plus a queue-based model of the expected write stream.
module tb_codec_config_sequencer;

    localparam int TRIES   = 4;
    localparam int TIMEOUT = 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i2c_start;
    logic [23:0] i2c_data;
    logic        i2c_done = 1'b1;
    logic        i2c_ack = 1'b0;
    logic        reconfig = 1'b0;
    logic        wr_req = 1'b0;
    logic [6:0]  wr_addr = 7'h00;
    logic [8:0]  wr_data = 9'h000;
    logic        wr_ack;
    logic        cfg_done;
    logic        cfg_error;
    logic [3:0]  err_index;

    codec_config_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .i2c_start (i2c_start),
        .i2c_data  (i2c_data),
        .i2c_done  (i2c_done),
        .i2c_ack   (i2c_ack),
        .reconfig  (reconfig),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .cfg_done  (cfg_done),
        .cfg_error (cfg_error),
        .err_index (err_index)
    );

    always #5 clk = ~clk;

    // Expected I2C words, written out by hand from the WM8731 init sequence.
    logic [23:0] tbl [10] = '{24'h341E00, 24'h340017, 24'h340217, 24'h340479, 24'h340679,
                              24'h340812, 24'h340A00, 24'h340C00, 24'h340E42, 24'h341201};

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [24:0] exp_q [$];
    int exp_wrack = 0;
    int exp_fail = 0;
    int exp_err_idx = 0;
    int exp_total = 0;

    int          sl_phase = 0;
    int          sl_d1 = 0;
    int          sl_d2 = 0;
    logic [23:0] sl_word = '0;
    bit          stuck_mode = 0;
    int          nack_idx = 0;
    int          nack_left = 0;

    int          n_starts = 0;
    int          n_idx_starts [10];
    logic [23:0] first_word = '0;
    bit          await_first = 0;
    int          rel_cyc = 0;
    int          last_start_cyc = -1;
    int          wrack_count = 0;
    bit          prev_start = 0;
    bit          prev_wrack = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected write stream: each entry is tried until ACKed or TRIES attempts are used.
    task automatic build_model(input int nidx, input int ntimes);
        int n;
        int tries;
        exp_q.delete();
        exp_fail = 0;
        exp_err_idx = 0;
        for (int i = 0; i < 10; i++) begin
            if (exp_fail == 0) begin
                n = (i == nidx) ? ntimes : 0;
                tries = (n + 1 > TRIES) ? TRIES : n + 1;
                for (int k = 0; k < tries; k++) exp_q.push_back({1'b0, tbl[i]});
                if (n >= TRIES) begin
                    exp_fail = 1;
                    exp_err_idx = i;
                end
            end
        end
        exp_total = exp_q.size();
        nack_idx = (nidx < 0) ? 0 : nidx;
        nack_left = (nidx < 0) ? 0 : ntimes;
        n_starts = 0;
        for (int i = 0; i < 10; i++) n_idx_starts[i] = 0;
    endtask

    task automatic pulse_reconfig();
        reconfig = 1'b1;
        tick(1);
        reconfig = 1'b0;
    endtask

    task automatic release_reset();
        reset = 1'b0;
        rel_cyc = cyc;
        await_first = 1;
    endtask

    task automatic wait_finish(input int budget, input string nm);
        int n = 0;
        while (!(exp_q.size() == 0 && (cfg_done || cfg_error)) && n < budget) begin
            tick(1);
            n++;
        end
        check({nm, "_bound"}, n < budget, 1);
        tick(20);
    endtask

    task automatic wait_busy_on(input logic [23:0] w, input string nm);
        int n = 0;
        while (!(sl_phase == 2 && sl_word == w) && n < 3000) begin
            tick(1);
            n++;
        end
        check({nm, "_bound"}, n < 3000, 1);
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_start"}, i2c_start, 0);
        check({nm, "_data"}, i2c_data, 0);
        check({nm, "_wr_ack"}, wr_ack, 0);
        check({nm, "_cfg_done"}, cfg_done, 0);
        check({nm, "_cfg_error"}, cfg_error, 0);
        check({nm, "_err_index"}, err_index, 0);
    endtask

    always @(posedge clk) cyc++;

    // Slave stub and every-cycle output checker share one process to keep ordering fixed.
    always @(negedge clk) begin
        logic [24:0] e;
        int g;
        if (reset) begin
            sl_phase = 0;
            i2c_done = 1'b1;
            i2c_ack = 1'b0;
            prev_start = 0;
            prev_wrack = 0;
            last_start_cyc = -1;
        end else begin
            if (i2c_start) begin
                check("start_single_cycle", prev_start, 0);
                if (!stuck_mode) check("start_while_busy", sl_phase, 0);
                check("start_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("start_word", i2c_data, e[23:0]);
                    check("cfg_done_at_start", cfg_done, e[24]);
                end
                if (await_first) begin
                    check("start_after_reset_latency", (cyc - rel_cyc) >= 2, 1);
                    await_first = 0;
                end
                if (stuck_mode && last_start_cyc >= 0) begin
                    g = cyc - last_start_cyc;
                    check("timeout_gap", (g >= TIMEOUT) && (g <= TIMEOUT + 40), 1);
                end
                last_start_cyc = cyc;
                n_starts++;
                if (n_starts == 1) first_word = i2c_data;
                for (int i = 0; i < 10; i++) if (i2c_data == tbl[i]) n_idx_starts[i]++;
                sl_word = i2c_data;
                sl_d1 = $urandom_range(0, 3);
                if (sl_d1 == 0) begin
                    i2c_done = 1'b0;
                    i2c_ack = 1'b0;
                    sl_phase = 2;
                    sl_d2 = $urandom_range(2, 12);
                end else begin
                    sl_phase = 1;
                end
            end else begin
                if (sl_phase != 0) check("data_stable", i2c_data, sl_word);
                case (sl_phase)
                    1: begin
                        sl_d1--;
                        if (sl_d1 == 0) begin
                            i2c_done = 1'b0;
                            i2c_ack = 1'b0;
                            sl_phase = 2;
                            sl_d2 = $urandom_range(2, 12);
                        end
                    end
                    2: begin
                        if (!stuck_mode) begin
                            sl_d2--;
                            if (sl_d2 == 0) begin
                                i2c_done = 1'b1;
                                i2c_ack = !(nack_left > 0 && sl_word == tbl[nack_idx]);
                                if (!i2c_ack) nack_left--;
                                sl_phase = 0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            if (wr_ack) begin
                check("wr_ack_single_cycle", prev_wrack, 0);
                check("wr_ack_expected", exp_wrack > 0, 1);
                check("wr_ack_after_write", exp_q.size(), 0);
                if (exp_wrack > 0) exp_wrack--;
                wrack_count++;
            end
            prev_start = i2c_start;
            prev_wrack = wr_ack;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int nidx;
        int nt;
        int wn;
        int wrack_snap;

        // Reset values, then init with a runtime request already waiting.
        tick(3);
        check_reset_outputs("reset");
        build_model(-1, 0);
        exp_q.push_back({1'b1, 24'h340479});
        exp_wrack = 1;
        wr_req = 1'b1;
        wr_addr = 7'h02;
        wr_data = 9'h079;
        release_reset();
        wn = 0;
        while (!wr_ack && wn < 4000) begin
            tick(1);
            wn++;
        end
        check("a_wr_ack_bound", wn < 4000, 1);
        wr_req = 1'b0;
        tick(40);
        check("a_n_starts", n_starts, 11);
        check("a_first_word", first_word, 24'h341E00);
        check("a_cfg_done", cfg_done, 1);
        check("a_cfg_error", cfg_error, 0);
        check("a_wr_ack_count", wrack_count, 1);

        // Entry 3 NACKed twice, then ACKed.
        build_model(3, 2);
        pulse_reconfig();
        wait_finish(4000, "b");
        check("b_entry3_starts", n_idx_starts[3], 3);
        check("b_n_starts", n_starts, 12);
        check("b_cfg_done", cfg_done, 1);
        check("b_cfg_error", cfg_error, 0);

        // Entry 5 always NACKed: halt, and runtime writes are ignored.
        build_model(5, 1000);
        pulse_reconfig();
        wait_finish(4000, "c");
        check("c_entry5_starts", n_idx_starts[5], 4);
        check("c_n_starts", n_starts, 9);
        check("c_cfg_error", cfg_error, 1);
        check("c_err_index", err_index, 5);
        check("c_cfg_done", cfg_done, 0);
        wrack_snap = wrack_count;
        wr_req = 1'b1;
        wr_addr = 7'h05;
        wr_data = 9'h011;
        tick(100);
        wr_req = 1'b0;
        check("c_halt_no_wr_ack", wrack_count, wrack_snap);
        check("c_halt_no_start", n_starts, 9);

        // Random NACK placement and count.
        for (int r = 0; r < 3; r++) begin
            nidx = $urandom_range(0, 9);
            nt = $urandom_range(0, 5);
            build_model(nidx, nt);
            pulse_reconfig();
            wait_finish(4000, "d");
            check("d_n_starts", n_starts, exp_total);
            check("d_cfg_done", cfg_done, (exp_fail == 0));
            check("d_cfg_error", cfg_error, exp_fail);
            if (exp_fail != 0) check("d_err_index", err_index, exp_err_idx);
        end

        // Reconfig during a transfer restarts after it; reset mid-transfer abandons it.
        build_model(-1, 0);
        pulse_reconfig();
        wait_busy_on(tbl[2], "e_entry2");
        build_model(-1, 0);
        pulse_reconfig();
        wait_busy_on(tbl[4], "e_entry4");
        check("e_restart_entry0_seen", n_idx_starts[0], 1);
        reset = 1'b1;
        tick(1);
        check_reset_outputs("e_reset");
        build_model(-1, 0);
        tick(1);
        release_reset();
        wait_finish(4000, "e");
        check("e_n_starts", n_starts, 10);
        check("e_first_word", first_word, 24'h341E00);
        check("e_cfg_done", cfg_done, 1);

        // Controller never completes: every attempt times out.
        stuck_mode = 1;
        build_model(0, TRIES);
        reset = 1'b1;
        tick(2);
        release_reset();
        wait_finish(20000, "f");
        check("f_n_starts", n_starts, 4);
        check("f_cfg_error", cfg_error, 1);
        check("f_err_index", err_index, 0);
        check("f_cfg_done", cfg_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
